// File: rtl/cpu_types_pkg.sv
// Shared CPU types: hazard controller FSM states and register-index type.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN,
    DWAIT,
    HALT
  } hazard_state_t;

  typedef logic [4:0] regbits_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID-stage read of a register an EX-stage load is about to write.
module hazard_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_memread,
  output logic             luse
);

  // Register zero is hardwired, so a load targeting it never creates a dependency.
  always_comb begin
    luse = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: per-cycle advance/stall/bubble decisions for the PC and the four
// pipeline registers, with a RUN/DWAIT/HALT FSM and stall/flush performance counters.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic             mem_pcsrc,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             wb_halt,
  output logic             pc_wen,
  output logic             if_id_wen,
  output logic             id_ex_wen,
  output logic             ex_mem_wen,
  output logic             mem_wb_wen,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             dmem_wait,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  hazard_state_t    state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             luse;
  logic             dmem_stall;
  logic             stall_inc, flush_inc;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_rt      (ex_rt),
    .ex_memread (ex_memread),
    .luse       (luse)
  );

  // Once in DWAIT the wait persists until dhit, even if the MEM-stage request bits drop.
  assign dmem_stall = ((state_q == DWAIT) || mem_memread || mem_memwrite) && !dhit;

  always_comb begin
    pc_wen       = 1'b0;
    if_id_wen    = 1'b0;
    id_ex_wen    = 1'b0;
    ex_mem_wen   = 1'b0;
    mem_wb_wen   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    flush_inc    = 1'b0;
    state_d      = state_q;

    if (!nRST) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        HALT: ;
        RUN, DWAIT: begin
          if (wb_halt) begin
            mem_wb_wen = 1'b1;
            state_d    = HALT;
          end else if (dmem_stall) begin
            state_d = DWAIT;
          end else begin
            state_d    = RUN;
            if_id_wen  = 1'b1;
            id_ex_wen  = 1'b1;
            ex_mem_wen = 1'b1;
            mem_wb_wen = 1'b1;
            if (mem_pcsrc) begin
              pc_wen       = 1'b1;
              if_id_flush  = 1'b1;
              id_ex_flush  = 1'b1;
              ex_mem_flush = 1'b1;
              flush_inc    = 1'b1;
            end else if (luse) begin
              if_id_wen   = 1'b0;
              id_ex_flush = 1'b1;
            end else if (!ihit) begin
              if_id_flush = 1'b1;
            end else begin
              pc_wen = 1'b1;
            end
          end
        end
        default: state_d = RUN;
      endcase
    end

    stall_inc = nRST && (state_q != HALT) && !pc_wen;
    dmem_wait = nRST && (state_q == DWAIT);
    halted    = nRST && (state_q == HALT);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (stall_inc) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (flush_inc) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random traffic
// compared every cycle against a priority-rule reference model.
module tb_pipeline_hazard_ctrl;

  logic        CLK, nRST;
  logic        ihit, dhit, mem_memread, mem_memwrite, mem_pcsrc, ex_memread, wb_halt;
  logic [4:0]  ex_rt, id_rs, id_rt;
  logic        pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, dmem_wait, halted;
  logic [31:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(
    .REG_W (5),
    .CNT_W (32)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .dhit         (dhit),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .mem_pcsrc    (mem_pcsrc),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .wb_halt      (wb_halt),
    .pc_wen       (pc_wen),
    .if_id_wen    (if_id_wen),
    .id_ex_wen    (id_ex_wen),
    .ex_mem_wen   (ex_mem_wen),
    .mem_wb_wen   (mem_wb_wen),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .dmem_wait    (dmem_wait),
    .halted       (halted),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model state: 0 = running, 1 = waiting on data memory, 2 = halted.
  int          ms;
  bit          known;
  logic [31:0] m_stall, m_flush;
  int          tests, fails;
  logic [7:0]  obs;
  logic        obs_dw, obs_h;
  logic [31:0] base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output vector order: pc, if_id, id_ex, ex_mem, mem_wb wens, then if_id, id_ex, ex_mem flushes.
  task automatic model(output logic [7:0] e, output logic edw, output logic eh,
                       output int ns, output bit si, output bit fi);
    bit lu;
    lu  = ex_memread && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
    e   = 8'h00;
    edw = 1'b0;
    eh  = 1'b0;
    ns  = ms;
    si  = 1'b0;
    fi  = 1'b0;
    if (!nRST) begin
      ns = 0;
    end else if (ms == 2) begin
      eh = 1'b1;
    end else begin
      edw = (ms == 1);
      if (wb_halt) begin
        e  = 8'b0000_1000;
        ns = 2;
      end else if (!dhit && (ms == 1 || mem_memread || mem_memwrite)) begin
        ns = 1;
      end else begin
        ns = 0;
        if (mem_pcsrc) begin
          e  = 8'b1111_1111;
          fi = 1'b1;
        end else if (lu)    e = 8'b0011_1010;
        else if (!ihit)     e = 8'b0111_1100;
        else                e = 8'b1111_1000;
      end
      si = !e[7];
    end
  endtask

  task automatic cycle();
    logic [7:0] e;
    logic       edw, eh;
    int         ns;
    bit         si, fi;
    #2;
    model(e, edw, eh, ns, si, fi);
    obs    = {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
              if_id_flush, id_ex_flush, ex_mem_flush};
    obs_dw = dmem_wait;
    obs_h  = halted;
    chk("outputs", {24'h0, obs}, {24'h0, e});
    chk("dmem_wait", {31'h0, obs_dw}, {31'h0, edw});
    chk("halted", {31'h0, obs_h}, {31'h0, eh});
    if (known) begin
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
    end
    @(posedge CLK);
    if (!nRST) begin
      ms      = 0;
      m_stall = 0;
      m_flush = 0;
      known   = 1'b1;
    end else begin
      ms      = ns;
      m_stall = m_stall + 32'(si);
      m_flush = m_flush + 32'(fi);
    end
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; mem_memread = 1'b0; mem_memwrite = 1'b0; mem_pcsrc = 1'b0;
    ex_memread = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; wb_halt = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; ms = 0; known = 1'b0; m_stall = 0; m_flush = 0;
    idle_inputs();
    nRST = 1'b0;

    // Reset held for two edges, then the first running cycle.
    cycle();
    chk("rst_outs0", {24'h0, obs}, 32'h0);
    cycle();
    chk("rst_outs1", {24'h0, obs}, 32'h0);
    nRST = 1'b1;
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    cycle();
    chk("first_run", {24'h0, obs}, 32'hF8);

    // Load-use against rs, then a load to register zero which must not stall.
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd3;
    cycle();
    chk("luse_outs", {24'h0, obs}, 32'h3A);
    chk("luse_stall_cnt", stall_cnt, 32'd1);
    ex_rt = 5'd0; id_rs = 5'd0;
    cycle();
    chk("luse_r0_outs", {24'h0, obs}, 32'hF8);

    // Three-cycle data-memory wait released by dhit.
    idle_inputs();
    base = stall_cnt;
    mem_memread = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("dwait_outs", {24'h0, obs}, 32'h0);
      chk("dwait_flag", {31'h0, obs_dw}, (i == 0) ? 32'd0 : 32'd1);
    end
    dhit = 1'b1;
    cycle();
    chk("dwait_release", {24'h0, obs}, 32'hF8);
    chk("dwait_release_flag", {31'h0, obs_dw}, 32'd1);
    chk("dwait_stall_cnt", stall_cnt, base + 32'd3);

    // Redirect held behind a store miss, applied on the dhit cycle.
    idle_inputs();
    base = flush_cnt;
    mem_pcsrc = 1'b1; mem_memwrite = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("defer_outs", {24'h0, obs}, 32'h0);
    end
    dhit = 1'b1;
    cycle();
    chk("defer_redirect", {24'h0, obs}, 32'hFF);
    chk("defer_flush_cnt", flush_cnt, base + 32'd1);

    // Redirect beats load-use and fetch stall.
    idle_inputs();
    mem_pcsrc = 1'b1; ihit = 1'b0; ex_memread = 1'b1; ex_rt = 5'd5; id_rt = 5'd5;
    cycle();
    chk("prio_redirect", {24'h0, obs}, 32'hFF);

    // Halt: retire only into MEM/WB, then frozen until reset.
    idle_inputs();
    wb_halt = 1'b1;
    cycle();
    chk("halt_retire", {24'h0, obs}, 32'h08);
    base = stall_cnt;
    for (int i = 0; i < 10; i++) begin
      {ihit, dhit, mem_memread, mem_memwrite, mem_pcsrc, ex_memread, wb_halt} = 7'($urandom);
      cycle();
      chk("halt_outs", {24'h0, obs}, 32'h0);
      chk("halt_flag", {31'h0, obs_h}, 32'd1);
    end
    chk("halt_cnt_frozen", stall_cnt, base);
    idle_inputs();
    nRST = 1'b0;
    cycle();
    nRST = 1'b1;
    cycle();
    chk("halt_exit", {31'h0, obs_h}, 32'd0);
    chk("halt_exit_outs", {24'h0, obs}, 32'hF8);

    // Random traffic with occasional resets and halts.
    for (int i = 0; i < 3000; i++) begin
      nRST         = ($urandom_range(0, 49) != 0);
      ihit         = ($urandom_range(0, 3) != 0);
      dhit         = ($urandom_range(0, 2) != 0);
      mem_memread  = ($urandom_range(0, 3) == 0);
      mem_memwrite = ($urandom_range(0, 4) == 0);
      mem_pcsrc    = ($urandom_range(0, 4) == 0);
      ex_memread   = ($urandom_range(0, 2) == 0);
      ex_rt        = 5'($urandom_range(0, 3));
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      wb_halt      = ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Each cycle it decides which register advances, stalls, or loads a bubble, using:
  - instruction/data memory handshakes (ihit/dhit)
  - load-use detection
  - taken branch/jump resolution in MEM
  - halt retirement
- Holds a small FSM for memory-wait and halt, plus stall/flush performance counters.

Parameters:
- REG_W, 5, register index width (rs/rt/rd fields).
- CNT_W, 32, width of performance counters.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  synchronous active-low reset, sampled on posedge CLK.
- ihit  in  1  instruction memory returned valid instruction this cycle.
- dhit  in  1  data memory completed the MEM-stage access this cycle.
- mem_memread  in  1  MEM-stage instruction is a load.
- mem_memwrite  in  1  MEM-stage instruction is a store.
- mem_pcsrc  in  1  MEM-stage branch taken or jump (redirect PC).
- ex_memread  in  1  EX-stage instruction is a load.
- ex_rt  in  REG_W  EX-stage load destination.
- id_rs  in  REG_W  ID-stage source register 1.
- id_rt  in  REG_W  ID-stage source register 2.
- wb_halt  in  1  HALT instruction in WB.
- pc_wen  out  1  PC update enable.
- if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen  out  1 each  register write enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load bubble (all zero) on next edge; only meaningful with matching wen=1.
- dmem_wait  out  1  FSM in DWAIT.
- halted  out  1  FSM in HALT.
- stall_cnt  out  CNT_W  cycles with pc_wen=0 while in RUN/DWAIT.
- flush_cnt  out  CNT_W  cycles with mem_pcsrc redirect applied.

Behaviour:
- FSM states: RUN, DWAIT, HALT. All state and counters are synchronous on posedge CLK.
- Reset (nRST=0 at an edge):
  - state <= RUN; counters <= 0.
  - While nRST=0, outputs are combinationally forced: all wen=0, all flush=0, dmem_wait=0, halted=0.
  - Reset mid-DWAIT or mid-HALT returns to RUN.
- Priority of per-cycle decisions in RUN/DWAIT, highest first:
  1. dmem stall: (mem_memread|mem_memwrite) & !dhit.
     - All wen=0, pc_wen=0, no flush.
     - Next state DWAIT.
     - A pending mem_pcsrc is deferred; it stays held in EX/MEM.
  2. redirect: mem_pcsrc=1 and no dmem stall.
     - pc_wen=1, all wen=1.
     - if_id_flush=id_ex_flush=ex_mem_flush=1.
     - flush_cnt += 1.
     - Ignores ihit and load-use.
  3. load-use: ex_memread & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
     - pc_wen=0, if_id_wen=0, id_ex_wen=1 with id_ex_flush=1.
     - ex_mem_wen=mem_wb_wen=1.
  4. fetch stall: !ihit.
     - pc_wen=0, if_id_wen=1 with if_id_flush=1.
     - Downstream wen=1.
  5. otherwise: all wen=1, pc_wen=1, no flush.
- DWAIT: outputs per rule 1 until dhit=1.
  - On the dhit cycle, rules 2-5 apply normally and next state is RUN.
  - Same-cycle dhit & mem_pcsrc → redirect is applied in that cycle.
- wb_halt=1 in RUN/DWAIT:
  - mem_wb_wen=1 that cycle, all other wen=0, pc_wen=0.
  - Next state HALT.
  - wb_halt overrides rules 1-5.
- HALT: all wen=0, pc_wen=0, halted=1, counters frozen. Exit only via reset.
- stall_cnt increments in any non-HALT cycle with pc_wen=0.
- Counters wrap modulo 2^CNT_W.
- All outputs except the FSM flags are combinational from state and inputs; dmem_wait and halted decode the registered state.

Decomposition:
- cpu_types_pkg gains:
  - hazard_state_t enum {RUN, DWAIT, HALT}
  - regbits_t (logic [4:0])
- Natural sub-module: hazard_detect, the combinational load-use comparator (id_rs, id_rt, ex_rt, ex_memread → luse).
- The FSM, priority mux and counters stay in pipeline_hazard_ctrl.

Test Plan:
- Reset: hold nRST=0 for 2 edges, then release → all wen=0 during reset, state RUN after release, stall_cnt=flush_cnt=0; with ihit=1, first cycle gives all wen=1 and pc_wen=1.
- Load-use: ex_memread=1, ex_rt=8, id_rs=8, ihit=1 → pc_wen=0, if_id_wen=0, id_ex_flush=1; stall_cnt=1 next cycle. Repeat with ex_rt=0 → no stall.
- Dmem wait: mem_memread=1, dhit=0 for 3 cycles, then dhit=1 → 3 cycles all wen=0, dmem_wait=1 from cycle 2 to 4, release cycle all wen=1, stall_cnt=3.
- Deferred redirect: mem_pcsrc=1, mem_memwrite=1, dhit=0 for 2 cycles, then dhit=1 → no flush for 2 cycles, then 3 flushes asserted in the dhit cycle, flush_cnt=1.
- Priority: mem_pcsrc=1 with a load-use match and ihit=0 in the same cycle → redirect only: pc_wen=1, three flushes, if_id_wen=1.
- Halt: wb_halt=1 → only mem_wb_wen=1 that cycle, then halted=1 and all wen=0 for 10 cycles regardless of inputs; nRST=0 for one edge → RUN, halted=0.
